// File: rtl/uart_rx_param_if.sv
// Receive-side word handshake for uart_rx_param: held word, valid/ready and
// per-word status flags.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] out;
    logic                 valid;
    logic                 ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output out, valid, parity_err, frame_err, overrun,
        input  ready
    );

    modport slave (
        input  out, valid, parity_err, frame_err, overrun,
        output ready
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, 3-sample majority vote,
// configurable data/parity/stop bits, single holding register with valid/ready.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 1992,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            in,
    uart_rx_param_if.master bus
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1   = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic          ODD       = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t state, state_n;

    logic [1:0]           sync;
    logic [2:0]           hist;
    logic                 rx_s, bit_v;
    logic [CW-1:0]        cnt;
    logic [2:0]           idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr_acc, ferr_acc;
    logic                 smp, last_stop;
    logic                 pend, pend_perr, pend_ferr;
    logic [DATA_BITS-1:0] pend_data;
    logic [DATA_BITS-1:0] out_q;
    logic                 valid_q, perr_q, ferr_q, ovr_q;

    assign rx_s  = sync[1];
    assign bit_v = (hist[0] & hist[1]) | (hist[1] & hist[2]) | (hist[0] & hist[2]);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync <= '1;
            hist <= '1;
        end else begin
            sync <= {sync[0], in};
            hist <= {hist[1:0], rx_s};
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        smp       = 1'b0;
        last_stop = 1'b0;
        case (state)
            S_IDLE: if (!rx_s) state_n = S_START;
            S_START: if (cnt == HALF_M1) begin
                smp     = 1'b1;
                state_n = bit_v ? S_IDLE : S_DATA;
            end
            S_DATA: if (cnt == FULL_M1) begin
                smp = 1'b1;
                if (idx == DATA_LAST) state_n = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: if (cnt == FULL_M1) begin
                smp     = 1'b1;
                state_n = S_STOP;
            end
            S_STOP: if (cnt == FULL_M1) begin
                smp = 1'b1;
                if (idx == STOP_LAST) begin
                    last_stop = 1'b1;
                    state_n   = (ferr_acc || !bit_v) ? S_BREAK : S_IDLE;
                end
            end
            S_BREAK: if (rx_s) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Data shifts in from the top so that after DATA_BITS samples the first
    // (LSB) bit sits at position 0, same result as indexed placement.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            perr_acc  <= 1'b0;
            ferr_acc  <= 1'b0;
            pend      <= 1'b0;
            pend_data <= '0;
            pend_perr <= 1'b0;
            pend_ferr <= 1'b0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            cnt <= (state_n != state || smp || state == S_IDLE) ? '0 : cnt + 1'b1;
            if (state_n != state) idx <= '0;
            else if (smp)         idx <= idx + 1'b1;

            if (state == S_IDLE && state_n == S_START) begin
                perr_acc <= 1'b0;
                ferr_acc <= 1'b0;
            end
            if (smp && state == S_DATA)   shreg    <= {bit_v, shreg[DATA_BITS-1:1]};
            if (smp && state == S_PARITY) perr_acc <= ^{shreg, bit_v} ^ ODD;
            if (smp && state == S_STOP && !bit_v) ferr_acc <= 1'b1;

            pend <= last_stop;
            if (last_stop) begin
                pend_data <= shreg;
                pend_perr <= perr_acc;
                pend_ferr <= ferr_acc | ~bit_v;
            end

            if (pend) begin
                if (!valid_q || bus.ready) begin
                    out_q   <= pend_data;
                    perr_q  <= pend_perr;
                    ferr_q  <= pend_ferr;
                    valid_q <= 1'b1;
                    ovr_q   <= 1'b0;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (valid_q && bus.ready) begin
                valid_q <= 1'b0;
                perr_q  <= 1'b0;
                ferr_q  <= 1'b0;
                ovr_q   <= 1'b0;
            end
        end
    end

    assign bus.out        = out_q;
    assign bus.valid      = valid_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;
    assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: an 8N1 and a 7E2 instance at 16 clocks
// per bit, directed frames with expected words queued at send time.
module tb_uart_rx_param;

    localparam int C = 16;

    logic CLK = 1'b0;
    logic RST_N;
    logic in_a, in_b;
    logic ready_a, ready_b;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int words_a = 0;
    int words_b = 0;

    logic [10:0] q_a[$];
    logic [10:0] q_b[$];

    always #5 CLK = ~CLK;

    uart_rx_param_if #(.DATA_BITS(8)) ifa ();
    uart_rx_param_if #(.DATA_BITS(7)) ifb ();

    assign ifa.ready = ready_a;
    assign ifb.ready = ready_b;

    uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .CLK(CLK), .RST_N(RST_N), .in(in_a), .bus(ifa.master)
    );

    uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_b (
        .CLK(CLK), .RST_N(RST_N), .in(in_b), .bus(ifb.master)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_bit(input int sel, input logic v, input bit spike);
        for (int c = 0; c < C; c++) begin
            logic lv;
            lv = (spike && c == C / 2 - 1) ? 1'b0 : v;
            if (sel == 0) in_a = lv;
            else          in_b = lv;
            tick();
        end
    endtask

    task automatic send_frame(input int sel, input logic [7:0] data, input int nd,
                              input bit has_par, input logic pbit, input int ns,
                              input int spike_bit);
        drive_bit(sel, 1'b0, 1'b0);
        for (int i = 0; i < nd; i++) drive_bit(sel, data[i], i == spike_bit);
        if (has_par) drive_bit(sel, pbit, 1'b0);
        for (int i = 0; i < ns; i++) drive_bit(sel, 1'b1, 1'b0);
    endtask

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    initial begin : mon_a
        logic pv;
        logic [10:0] got, e;
        pv = 1'b0;
        forever begin
            @(negedge CLK);
            if (!RST_N) pv = 1'b0;
            else begin
                if (ifa.valid && !pv) words_a++;
                pv = ifa.valid;
                if (ifa.valid && ready_a) begin
                    got = {ifa.out, ifa.parity_err, ifa.frame_err, ifa.overrun};
                    if (q_a.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL a_spurious: got word 0x%0h, want none", got);
                    end else begin
                        e = q_a.pop_front();
                        check("a_word", 32'(got), 32'(e));
                    end
                end
            end
        end
    end

    initial begin : mon_b
        logic pv;
        logic [10:0] got, e;
        pv = 1'b0;
        forever begin
            @(negedge CLK);
            if (!RST_N) pv = 1'b0;
            else begin
                if (ifb.valid && !pv) words_b++;
                pv = ifb.valid;
                if (ifb.valid && ready_b) begin
                    got = {1'b0, ifb.out, ifb.parity_err, ifb.frame_err, ifb.overrun};
                    if (q_b.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL b_spurious: got word 0x%0h, want none", got);
                    end else begin
                        e = q_b.pop_front();
                        check("b_word", 32'(got), 32'(e));
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int s, lat, w, idle_v;
        bit hit;

        RST_N = 1'b0; in_a = 1'b1; in_b = 1'b1; ready_a = 1'b1; ready_b = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            in_a = ~in_a;
            in_b = ~in_b;
        end
        @(negedge CLK);
        check("rst_out", 32'(ifa.out), 0);
        check("rst_valid", 32'({ifa.valid, ifb.valid}), 0);
        check("rst_perr", 32'({ifa.parity_err, ifb.parity_err}), 0);
        check("rst_ferr", 32'({ifa.frame_err, ifb.frame_err}), 0);
        check("rst_ovr", 32'({ifa.overrun, ifb.overrun}), 0);
        tick();
        in_a = 1'b1; in_b = 1'b1;
        tick();
        RST_N = 1'b1;

        idle_v = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge CLK);
            if (ifa.valid || ifb.valid) idle_v++;
        end
        check("idle_valid", 32'(idle_v), 0);

        // 8N1 0xA5: latency and single-cycle valid pulse
        tick();
        q_a.push_back({8'hA5, 3'b000});
        lat = -1;
        s = cyc + 1;
        fork
            send_frame(0, 8'hA5, 8, 1'b0, 1'b0, 1, -1);
            begin
                for (int i = 0; i < 300 && lat < 0; i++) begin
                    @(negedge CLK);
                    if (ifa.valid) lat = cyc - s;
                end
                check("a5_latency", 32'(lat), 155);
                @(negedge CLK);
                check("a5_pulse", 32'(ifa.valid), 0);
            end
        join
        repeat (2 * C) tick();

        // 7E2 0x3C back-to-back: correct parity then flipped parity
        q_b.push_back({1'b0, 7'h3C, 3'b000});
        send_frame(1, 8'h3C, 7, 1'b1, 1'b0, 2, -1);
        q_b.push_back({1'b0, 7'h3C, 3'b100});
        send_frame(1, 8'h3C, 7, 1'b1, 1'b1, 2, -1);
        repeat (2 * C) tick();
        check("b_words", 32'(words_b), 2);

        // 3-cycle low pulse is a false start
        w = words_a;
        in_a = 1'b0;
        repeat (3) tick();
        in_a = 1'b1;
        repeat (3 * C) tick();
        check("glitch_words", 32'(words_a - w), 0);

        // single-cycle spike inside a '1' data bit is voted out
        q_a.push_back({8'hFF, 3'b000});
        send_frame(0, 8'hFF, 8, 1'b0, 1'b0, 1, 3);
        repeat (2 * C) tick();
        check("spike_words", 32'(words_a - w), 1);

        // overrun: second word dropped while first is held
        ready_a = 1'b0;
        send_frame(0, 8'h11, 8, 1'b0, 1'b0, 1, -1);
        send_frame(0, 8'h22, 8, 1'b0, 1'b0, 1, -1);
        repeat (2) tick();
        @(negedge CLK);
        check("ovr_valid", 32'(ifa.valid), 1);
        check("ovr_out", 32'(ifa.out), 32'h11);
        check("ovr_flag", 32'(ifa.overrun), 1);
        q_a.push_back({8'h11, 3'b001});
        tick();
        ready_a = 1'b1;
        tick();
        @(negedge CLK);
        check("drain_valid", 32'(ifa.valid), 0);
        check("drain_ovr", 32'(ifa.overrun), 0);

        // ready pulsed in the delivery cycle of the second word: no overrun
        tick();
        ready_a = 1'b0;
        q_a.push_back({8'h11, 3'b000});
        send_frame(0, 8'h11, 8, 1'b0, 1'b0, 1, -1);
        hit = 1'b0;
        s = cyc + 1;
        fork
            send_frame(0, 8'h22, 8, 1'b0, 1'b0, 1, -1);
            begin
                for (int i = 0; i < 400 && !hit; i++) begin
                    tick();
                    if (cyc == s + 154) hit = 1'b1;
                end
                ready_a = 1'b1;
                tick();
                ready_a = 1'b0;
            end
        join
        check("pulse_sync", 32'(hit), 1);
        @(negedge CLK);
        check("pulse_valid", 32'(ifa.valid), 1);
        check("pulse_out", 32'(ifa.out), 32'h22);
        check("pulse_ovr", 32'(ifa.overrun), 0);
        q_a.push_back({8'h22, 3'b000});
        tick();
        ready_a = 1'b1;
        repeat (4) tick();

        // break: line low for 30 bit times gives one framing-error word
        w = words_a;
        q_a.push_back({8'h00, 3'b010});
        in_a = 1'b0;
        repeat (30 * C) tick();
        in_a = 1'b1;
        repeat (4 * C) tick();
        check("break_words", 32'(words_a - w), 1);
        q_a.push_back({8'h5A, 3'b000});
        send_frame(0, 8'h5A, 8, 1'b0, 1'b0, 1, -1);
        repeat (2 * C) tick();
        check("post_break_words", 32'(words_a - w), 2);

        // reset pulse in data bit 4 (a '1') aborts the frame
        w = words_a;
        fork
            send_frame(0, 8'hF0, 8, 1'b0, 1'b0, 1, -1);
            begin
                repeat (5 * C + C / 2) tick();
                RST_N = 1'b0;
                repeat (2) tick();
                RST_N = 1'b1;
            end
        join
        repeat (2 * C) tick();
        check("midrst_words", 32'(words_a - w), 0);
        q_a.push_back({8'h3A, 3'b000});
        send_frame(0, 8'h3A, 8, 1'b0, 1'b0, 1, -1);
        repeat (2 * C) tick();
        check("recover_words", 32'(words_a - w), 1);

        check("a_queue_left", 32'(q_a.size()), 0);
        check("b_queue_left", 32'(q_b.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver: the successor to the core's fixed 8N1 serial receiver, used on the host link in front of the instruction/data loader. Adds configurable data width, parity and stop bits, and an input synchroniser with 3-sample majority vote. Each received word lands in a holding register with a valid/ready handshake, together with per-word parity, framing and overrun flags.

## Interface
- `CLKS_PER_BIT`, 1992: CLK cycles per bit period. Must be ≥ 8 and even.
- `DATA_BITS`, 8: data bits per frame, 5..8, LSB first.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `CLK` input 1: single clock; all logic posedge.
- `RST_N` input 1: reset, asynchronous, active-low.
- `in` input 1: serial line, asynchronous, idle high.
- `out` output DATA_BITS: received word; stable while `valid`.
- `valid` output 1: a word is held in `out`.
- `ready` input 1: consumer accepts the word when `valid && ready`.
- `parity_err` output 1: parity mismatch for the held word; always 0 when PARITY=0.
- `frame_err` output 1: a stop bit of the held word sampled low.
- `overrun` output 1: at least one frame was dropped while this word was held.

## Operation
- `in` passes through a 2-flop synchroniser (flops reset to 1) to give `rx_s`.
- A 3-deep history of `rx_s` feeds a majority vote, `bit_v`.
- Bit counter is width $clog2(CLKS_PER_BIT). It clears on every state entry and at every sample point.
- **IDLE**: when `rx_s==0`, go to START.
- **START**: sample `bit_v` at counter == CLKS_PER_BIT/2-1.
  - If `bit_v==1`: false start; return to IDLE with no output.
  - Else go to DATA.
- **DATA**: sample `bit_v` at counter == CLKS_PER_BIT-1 into shift register position [idx], LSB first. After DATA_BITS samples, go to PARITY (PARITY≠0) or STOP.
- **PARITY**: one sample.
  - Odd mode: error if XOR(data, pbit) != 1.
  - Even mode: error if XOR(data, pbit) != 0.
- **STOP**: STOP_BITS samples. frame_err is set if any stop sample is 0.
  - After the last stop sample, the frame is delivered.
  - If the frame is good, go to IDLE.
  - On frame_err, go to BREAK.
- **BREAK**: wait for `rx_s==1`, then go to IDLE. A held-low line (break) yields exactly one frame, with frame_err=1.
- **Delivery**, evaluated in the cycle after the last stop sample:
  - If `!valid`, or `valid && ready` in that cycle: load `out` and the error flags, `valid`=1, overrun=0.
  - Else: drop the new frame, keep `out`/`parity_err`/`frame_err`, set `overrun`=1.
- **Handshake**:
  - `valid && ready` with no delivery in that cycle: `valid`=0 next cycle, and all flags clear.
  - `ready` while `!valid` is ignored.
- **Reset**: on any assertion, even mid-frame, the block goes to IDLE.
  - `out`=0, `valid`=0, `parity_err`=0, `frame_err`=0, `overrun`=0.
  - Synchroniser and vote history are set to 1 and counters to 0.
  - After release, a partial frame still on the line must not produce a word until a fresh start bit is seen.

## Timing
- Let N be the first CLK edge that samples `in`=0.
- Sample points:
  - START sample at edge N+2+CLKS_PER_BIT/2.
  - Bit k sample at that edge + (k+1)·CLKS_PER_BIT.
- Let F = DATA_BITS + (PARITY≠0) + STOP_BITS.
- `valid` rises at edge N+3+CLKS_PER_BIT/2+F·CLKS_PER_BIT.
- Example, CLKS_PER_BIT=16, 8N1: `valid` high after edge N+155.
- All outputs are registered; no combinational path from `in` or `ready`.
- Back-to-back frames with zero idle between stop and next start must be received.
- With `ready` held high, throughput is one word per frame.

## Test plan
- Reset/idle: assert RST_N=0 with `in` toggling -> all outputs 0. Release with `in`=1 -> `valid` stays 0 for 1000 cycles.
- 8N1 at CLKS_PER_BIT=16: send 0xA5 with `ready`=1 -> `out`=0xA5 and `valid` pulses one cycle at N+155. All flags 0.
- 7E2: send 0x3C with the correct parity bit -> `parity_err`=0. Resend with the parity bit flipped -> `out`=0x3C, `parity_err`=1.
- Glitch/false start:
  - A 3-cycle low pulse on `in` -> no `valid`.
  - A 1-cycle low spike inside the data bit carrying a 1 of 0xFF -> `out`=0xFF.
- Overrun and handshake:
  - With `ready`=0, send 0x11 then 0x22 -> `out`=0x11, `overrun`=1. Raise `ready` -> `valid` and `overrun` fall.
  - Repeat with `ready` pulsed exactly in the delivery cycle of 0x22 -> `out`=0x22, `overrun`=0.
- Break/mid-frame reset:
  - Hold `in`=0 for 30 bit times -> one word 0x00 with `frame_err`=1. Then no further words until the line returns high and a new start bit arrives.
  - Pulse RST_N low during bit 4 of a frame -> no word is delivered.
